// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the I2S ADC receive path.
//   DW_DEF          - default sample width per channel
//   SYNC_STAGES_DEF - default synchronizer depth for codec-side inputs
//   ST_*            - receive FSM state encoding
package audio_pkg;

    localparam int DW_DEF          = 16;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_L  = 3'd1;
    localparam logic [2:0] ST_SKIP_L  = 3'd2;
    localparam logic [2:0] ST_SHIFT_L = 3'd3;
    localparam logic [2:0] ST_WAIT_R  = 3'd4;
    localparam logic [2:0] ST_SKIP_R  = 3'd5;
    localparam logic [2:0] ST_SHIFT_R = 3'd6;

endpackage

// File: rtl/audio_edge_sync.sv
// audio_edge_sync: brings one asynchronous codec signal into the clk_n domain
// and reports its edges.
//   clk_n  in  system clock (rising edge)
//   rst    in  asynchronous active-low reset
//   d      in  asynchronous input
//   level  out synchronized level
//   rise   out one-cycle pulse on synchronized 0->1
//   fall   out one-cycle pulse on synchronized 1->0
module audio_edge_sync
    import audio_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_n,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_n or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: I2S ADC receiver. Captures a left/right sample pair from the
// codec serial stream and offers it with a valid/ready handshake.
//   clk_n, rst            system clock, async active-low reset
//   init_done             codec configured; low forces IDLE
//   bclk/adclrck/adcdat   codec bit clock, frame clock (low=left), data
//   left_data/right_data  captured pair, held while valid && !ready
//   valid/ready           output handshake
//   overflow              sticky, a completed pair was dropped
//   busy                  FSM not idle
//   ovf_cnt               saturating dropped-pair count, only when
//                         AUDIO_ADC_RX_OVF_CNT_EN is defined
module audio_adc_rx
    import audio_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic          clk_n,
    input  logic          rst,
    input  logic          init_done,
    input  logic          bclk,
    input  logic          adclrck,
    input  logic          adcdat,
    output logic [DW-1:0] left_data,
    output logic [DW-1:0] right_data,
    output logic          valid,
    input  logic          ready,
    output logic          overflow,
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
    output logic [7:0]    ovf_cnt,
`endif
    output logic          busy
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic bclk_rise, lr_rise, lr_fall, dat_lvl;
    logic bclk_lvl, bclk_fall, lr_lvl, dat_rise, dat_fall;

    audio_edge_sync #(.STAGES(SYNC_STAGES)) u_bclk (
        .clk_n(clk_n), .rst(rst), .d(bclk),
        .level(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall));
    audio_edge_sync #(.STAGES(SYNC_STAGES)) u_lrck (
        .clk_n(clk_n), .rst(rst), .d(adclrck),
        .level(lr_lvl), .rise(lr_rise), .fall(lr_fall));
    audio_edge_sync #(.STAGES(SYNC_STAGES)) u_dat (
        .clk_n(clk_n), .rst(rst), .d(adcdat),
        .level(dat_lvl), .rise(dat_rise), .fall(dat_fall));

    logic unused_edges;
    assign unused_edges = ^{bclk_lvl, bclk_fall, lr_lvl, dat_rise, dat_fall};

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] sh_q, sh_d, lhold_q, lhold_d, shifted;
    logic [DW-1:0] left_q, right_q;
    logic          valid_q, ovf_q, pair_done, load, drop;

    // All three inputs pass through equal-depth synchronizers, so the data
    // level seen alongside a bclk rise is the bit the codec launched on the
    // preceding bclk fall.
    assign shifted = {sh_q[DW-2:0], dat_lvl};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        lhold_d   = lhold_q;
        pair_done = 1'b0;
        case (state_q)
            ST_IDLE:   if (init_done) state_d = ST_WAIT_L;
            ST_WAIT_L: if (lr_fall)   state_d = ST_SKIP_L;
            ST_WAIT_R: if (lr_rise)   state_d = ST_SKIP_R;
            ST_SKIP_L, ST_SKIP_R: begin
                // first bclk after the frame edge carries no sample bit
                if (bclk_rise) begin
                    state_d = (state_q == ST_SKIP_L) ? ST_SHIFT_L : ST_SHIFT_R;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
            ST_SHIFT_L, ST_SHIFT_R: begin
                // a frame edge before the word completes aborts the frame
                if (lr_fall) begin
                    state_d = ST_SKIP_L;
                end else if (lr_rise) begin
                    state_d = ST_WAIT_L;
                end else if (bclk_rise) begin
                    sh_d  = shifted;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        if (state_q == ST_SHIFT_L) begin
                            lhold_d = shifted;
                            state_d = ST_WAIT_R;
                        end else begin
                            pair_done = 1'b1;
                            state_d   = ST_WAIT_L;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!init_done) begin
            state_d   = ST_IDLE;
            pair_done = 1'b0;
        end
    end

    // A completed pair replaces the output only if the slot is free or being
    // emptied this same cycle; otherwise the held pair wins.
    assign load = pair_done && (!valid_q || ready);
    assign drop = pair_done && valid_q && !ready;

    always_ff @(posedge clk_n or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            lhold_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            lhold_q <= lhold_d;
            if (load) begin
                left_q  <= lhold_q;
                right_q <= shifted;
                valid_q <= 1'b1;
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

`ifdef AUDIO_ADC_RX_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;
    always_ff @(posedge clk_n or negedge rst) begin
        if (!rst)                          ovf_cnt_q <= 8'd0;
        else if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
    assign ovf_cnt = ovf_cnt_q;
`endif

    assign left_data  = left_q;
    assign right_data = right_q;
    assign valid      = valid_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_audio_adc_rx.sv
module tb_audio_adc_rx;
    localparam int DW   = 16;
    localparam int SLOT = 20;   // bclk cycles per channel slot

    logic clk_n = 0, rst = 1, init_done = 0, ready = 0;
    logic bclk = 0, adclrck = 1, adcdat = 0;
    logic [DW-1:0] left_data, right_data;
    logic valid, overflow, busy;
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
    logic [7:0] ovf_cnt;
`endif

    audio_adc_rx #(.DW(DW), .SYNC_STAGES(2)) dut (
        .clk_n(clk_n), .rst(rst), .init_done(init_done),
        .bclk(bclk), .adclrck(adclrck), .adcdat(adcdat),
        .left_data(left_data), .right_data(right_data),
        .valid(valid), .ready(ready), .overflow(overflow),
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
        .ovf_cnt(ovf_cnt),
`endif
        .busy(busy));

    always #4 clk_n = ~clk_n;   // 125 MHz

    int total = 0, bad = 0;
    int seen_valid = 0, seen_busy = 0;
    logic [2*DW-1:0] got[$];

    // Accepted pairs as the consumer sees them.
    always @(negedge clk_n) begin
        if (rst && valid && ready) got.push_back({left_data, right_data});
        if (valid) seen_valid++;
        if (busy)  seen_busy++;
    end

    // One bclk period (clk_n/8): data launched on the falling edge.
    task automatic bit_cyc(input logic d);
        bclk = 0; adcdat = d; #32;
        bclk = 1; #32;
    endtask

    // One channel slot: frame edge + delay bit, nbits of v MSB first, random
    // padding up to ncyc bit cycles after the delay bit.
    task automatic chan(input logic lr, input logic [DW-1:0] v,
                        input int nbits, input int ncyc);
        adclrck = lr;
        bit_cyc(1'($urandom_range(0, 1)));
        for (int i = 0; i < nbits; i++) bit_cyc(v[DW-1-i]);
        for (int i = nbits; i < ncyc; i++) bit_cyc(1'($urandom_range(0, 1)));
    endtask

    task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        chan(1'b0, l, DW, SLOT - 1);
        chan(1'b1, r, DW, SLOT - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_n);
    endtask

    task automatic check_pairs(input string name, input logic [2*DW-1:0] exp[$]);
        total++;
        if (got.size() !== exp.size()) begin
            bad++;
            $display("FAIL %s count got=%0d exp=%0d", name, got.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                total++;
                if (got[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL %s pair%0d got=%h exp=%h", name, i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({left_data, right_data, valid, overflow, busy} !== '0) begin
            bad++;
            $display("FAIL %s outputs got=%h/%h v=%b o=%b b=%b exp=all 0",
                     name, left_data, right_data, valid, overflow, busy);
        end
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
        total++;
        if (ovf_cnt !== 8'd0) begin
            bad++;
            $display("FAIL %s ovf_cnt got=%0d exp=0", name, ovf_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        idle(2);
        rst = 0; #1;
        check_zero("reset");
        idle(3);
        rst = 1;
        idle(3);
        check_zero("after_release");
    endtask

    task automatic test_no_init();
        logic [2*DW-1:0] exp[$];
        init_done = 0; ready = 1;
        got.delete(); seen_valid = 0; seen_busy = 0;
        frame(16'h1357, 16'h2468);
        frame(16'hBEEF, 16'hCAFE);
        idle(20);
        total++;
        if (seen_valid !== 0 || seen_busy !== 0) begin
            bad++;
            $display("FAIL no_init valid_cycles=%0d busy_cycles=%0d exp=0/0", seen_valid, seen_busy);
        end
        check_pairs("no_init", exp);
    endtask

    task automatic test_basic();
        logic [2*DW-1:0] exp[$];
        init_done = 1; ready = 1;
        idle(5);
        got.delete(); seen_valid = 0;
        frame(16'hA5C3, 16'h1234);
        idle(20);
        exp.push_back({16'hA5C3, 16'h1234});
        check_pairs("basic", exp);
        total++;
        if (seen_valid !== 1) begin
            bad++;
            $display("FAIL basic_pulse valid_cycles=%0d exp=1", seen_valid);
        end
    endtask

    task automatic test_random();
        logic [2*DW-1:0] exp[$];
        logic [DW-1:0] l, r;
        got.delete();
        for (int k = 0; k < 5; k++) begin
            l = DW'($urandom); r = DW'($urandom);
            exp.push_back({l, r});
            frame(l, r);
        end
        idle(20);
        check_pairs("random", exp);
    endtask

    task automatic test_overflow();
        logic [2*DW-1:0] exp[$];
        ready = 0;
        got.delete();
        frame(16'h1111, 16'h2222);
        frame(16'h3333, 16'h4444);
        idle(20);
        total++;
        if (valid !== 1'b1 || left_data !== 16'h1111 || right_data !== 16'h2222) begin
            bad++;
            $display("FAIL ovf_hold got v=%b %h/%h exp v=1 1111/2222", valid, left_data, right_data);
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag got=%b exp=1", overflow);
        end
`ifdef AUDIO_ADC_RX_OVF_CNT_EN
        total++;
        if (ovf_cnt !== 8'd1) begin
            bad++;
            $display("FAIL ovf_cnt got=%0d exp=1", ovf_cnt);
        end
`endif
        @(posedge clk_n); #1 ready = 1;
        idle(3);
        exp.push_back({16'h1111, 16'h2222});
        check_pairs("ovf_drain", exp);
        total++;
        if (valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_after got v=%b o=%b exp v=0 o=1", valid, overflow);
        end
    endtask

    task automatic test_abort();
        logic [2*DW-1:0] exp[$];
        got.delete(); seen_valid = 0;
        chan(1'b0, DW'($urandom), 10, 10);        // frame edge after 10 bits
        chan(1'b1, DW'($urandom), DW, SLOT - 1);
        frame(16'h7FFF, 16'h8000);
        idle(20);
        exp.push_back({16'h7FFF, 16'h8000});
        check_pairs("abort", exp);
        total++;
        if (seen_valid !== 1) begin
            bad++;
            $display("FAIL abort_pulses valid_cycles=%0d exp=1", seen_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [2*DW-1:0] exp[$];
        chan(1'b0, DW'($urandom), DW, SLOT - 1);
        adclrck = 1;
        bit_cyc(1'b0);
        for (int i = 0; i < 5; i++) bit_cyc(1'($urandom_range(0, 1)));
        #3 rst = 0; #1;
        check_zero("reset_mid");
        idle(3);
        rst = 1;
        idle(3);
        got.delete();
        frame(16'h0001, 16'hFFFF);
        idle(20);
        exp.push_back({16'h0001, 16'hFFFF});
        check_pairs("reset_mid_next", exp);
    endtask

    task automatic test_init_drop();
        logic [2*DW-1:0] exp[$];
        logic [DW-1:0] l, r;
        got.delete();
        adclrck = 0;
        bit_cyc(1'b1);
        for (int i = 0; i < 8; i++) bit_cyc(1'($urandom_range(0, 1)));
        @(negedge clk_n);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL drop_busy_before got=%b exp=1", busy);
        end
        init_done = 0;
        @(negedge clk_n);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_busy_after got=%b exp=0", busy);
        end
        seen_valid = 0;
        for (int i = 8; i < SLOT - 1; i++) bit_cyc(1'($urandom_range(0, 1)));
        chan(1'b1, DW'($urandom), DW, SLOT - 1);
        idle(20);
        total++;
        if (seen_valid !== 0) begin
            bad++;
            $display("FAIL drop_no_valid valid_cycles=%0d exp=0", seen_valid);
        end
        init_done = 1;
        idle(3);
        l = DW'($urandom); r = DW'($urandom);
        frame(l, r);
        idle(20);
        exp.push_back({l, r});
        check_pairs("drop_recover", exp);
    endtask

    initial begin
        test_reset();
        test_no_init();
        test_basic();
        test_random();
        test_overflow();
        test_abort();
        test_reset_mid();
        test_init_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_adc_rx.md
AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

Interface
REQ-001 SHALL have parameter DW, default 16, sample width per channel in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for codec-side inputs (min 2).
REQ-003 SHALL have port clk_n  in  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port init_done  in  1  codec configured (driven by the codec init block's finish output).
REQ-006 SHALL have port bclk  in  1  codec bit clock, asynchronous to clk_n.
REQ-007 SHALL have port adclrck  in  1  codec ADC frame clock; low = left, high = right.
REQ-008 SHALL have port adcdat  in  1  codec serial ADC data, MSB first.
REQ-009 SHALL have ports left_data / right_data  out  DW  captured sample pair.
REQ-010 SHALL have port valid  out  1  sample pair available.
REQ-011 SHALL have port ready  in  1  consumer accepts pair when valid && ready.
REQ-012 SHALL have port overflow  out  1  sticky, pair lost.
REQ-013 SHALL have port busy  out  1  high whenever state != IDLE.

Function
REQ-014 SHALL pass bclk, adclrck and adcdat through SYNC_STAGES flip-flops, then detect edges against one further registered copy.
REQ-015 SHALL implement states IDLE, WAIT_L, SKIP_L, SHIFT_L, WAIT_R, SKIP_R, SHIFT_R.
REQ-016 IDLE -> WAIT_L when init_done = 1; any state -> IDLE on the cycle after init_done = 0, partial frame discarded, output buffer untouched.
REQ-017 WAIT_L -> SKIP_L on adclrck falling edge; SKIP_L ignores the first bclk rising edge (I2S one-bit delay), then -> SHIFT_L.
REQ-018 SHIFT_L SHALL shift adcdat in on each bclk rising edge, MSB first; after DW bits -> WAIT_R; further bits before the frame edge ignored.
REQ-019 WAIT_R -> SKIP_R on adclrck rising edge; SKIP_R/SHIFT_R mirror REQ-017/018 for the right channel; after DW bits -> WAIT_L.
REQ-020 An adclrck edge arriving in SHIFT_L/SHIFT_R before DW bits SHALL discard the frame: falling edge -> SKIP_L, rising edge -> WAIT_L.
REQ-021 On the right channel's DW-th bit, the pair SHALL load into the output registers and valid SHALL rise the next clk_n cycle.
REQ-022 left_data/right_data SHALL be stable while valid = 1 and not accepted; valid clears the cycle after valid && ready unless a new pair loads that same cycle.
REQ-023 New pair completing while valid = 1 and ready = 0: new pair dropped, held pair kept, overflow set.
REQ-024 New pair completing in the same cycle as valid && ready: new pair loaded, valid stays 1, no overflow.
REQ-025 overflow SHALL clear only on reset.

Reset
REQ-026 rst = 0 SHALL immediately force state IDLE, synchronizers 0, shift register 0, left_data = 0, right_data = 0, valid = 0, overflow = 0, busy = 0.
REQ-027 Reset mid-frame SHALL discard all partial data; after release capture restarts at the next adclrck falling edge following init_done = 1.

Configuration
REQ-028 With AUDIO_ADC_RX_OVF_CNT_EN defined, SHALL add port ovf_cnt  out  8, incremented per dropped pair, saturating at 255, reset to 0.
REQ-029 Without AUDIO_ADC_RX_OVF_CNT_EN, ovf_cnt SHALL not exist; all other behaviour identical.

Structure
REQ-030 State encoding, DW default and SYNC_STAGES default SHALL live in shared package audio_pkg.
REQ-031 Synchronizer plus edge detector SHALL be sub-module audio_edge_sync (one instance per codec input, outputs level, rise, fall).

Verification (clk_n 125 MHz, bclk = clk_n/8, DW = 16)
REQ-032 init_done = 0, frames toggling -> valid = 0, busy = 0 throughout.
REQ-033 init_done = 1, ready = 1, frame L = 0xA5C3, R = 0x1234 -> one valid pulse, left_data = 0xA5C3, right_data = 0x1234.
REQ-034 ready = 0, frames 0x1111/0x2222 then 0x3333/0x4444 -> outputs hold 0x1111/0x2222, overflow = 1, ovf_cnt = 1 (macro on).
REQ-035 adclrck rises after 10 left bits -> no valid; next frame 0x7FFF/0x8000 captured exactly.
REQ-036 rst = 0 mid right channel -> all outputs 0 asynchronously; after release next frame 0x0001/0xFFFF captured.
REQ-037 init_done drops mid-left channel -> busy = 0 next cycle, no valid; re-raise -> next full frame captured.
